// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: streams key then query SRAM reads into the MAC array, stalls queries on FIFO back-pressure, drains, then pulses done
module mac_array_ctrl #(
  parameter int col = 8,
  parameter int aw = 6,
  parameter int qw = 5,
  parameter int key_base = 0,
  parameter int query_base = 16,
  parameter int load_len = col + 2,
  parameter int drain_len = col + 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [qw-1:0] num_q,
  input  logic          ofifo_full,
  output logic          mem_cen,
  output logic [aw-1:0] mem_addr,
  output logic [1:0]    inst,
  output logic          busy,
  output logic          done
);
  localparam int kw = load_len > 1 ? $clog2(load_len) : 1;
  localparam int dw = drain_len > 1 ? $clog2(drain_len) : 1;
  typedef enum logic [2:0] {idle, load, exec, drain, fin} state_t;
  state_t state_q, state_d;
  logic [kw-1:0] k_q, k_d;
  logic [dw-1:0] dc_q, dc_d;
  logic [qw-1:0] i_q, i_d, nq_q, nq_d;
  logic [aw-1:0] addr_q, addr_d;
  logic [1:0] inst_q, inst_d;
  logic cen_q, cen_d, busy_q, busy_d, done_q, done_d, issue;
  assign mem_cen = cen_q | (state_q == exec && ofifo_full);
  assign issue = ~mem_cen;
  assign mem_addr = addr_q;
  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    dc_d = dc_q;
    i_d = i_q;
    nq_d = nq_q;
    addr_d = addr_q;
    cen_d = cen_q;
    busy_d = busy_q;
    done_d = 1'b0;
    inst_d = issue ? (state_q == load ? 2'b01 : 2'b10) : 2'b00;
    case (state_q)
      idle: if (start) begin
        state_d = load;
        nq_d = num_q;
        i_d = '0;
        k_d = '0;
        cen_d = 1'b0;
        addr_d = aw'(key_base);
        busy_d = 1'b1;
      end
      load: if (k_q == kw'(load_len - 1)) begin
        state_d = nq_q == '0 ? drain : exec;
        cen_d = nq_q == '0;
        addr_d = aw'(query_base);
        dc_d = '0;
      end else begin
        k_d = k_q + 1'b1;
        addr_d = aw'(key_base) + aw'(k_q) + aw'(1);
      end
      exec: if (!ofifo_full) begin
        if (i_q == nq_q - 1'b1) begin
          state_d = drain;
          cen_d = 1'b1;
          dc_d = '0;
        end else begin
          i_d = i_q + 1'b1;
          addr_d = aw'(query_base) + aw'(i_q) + aw'(1);
        end
      end
      drain: if (dc_q == dw'(drain_len - 1)) begin
        state_d = fin;
        busy_d = 1'b0;
        done_d = 1'b1;
        addr_d = '0;
      end else begin
        dc_d = dc_q + 1'b1;
      end
      default: state_d = idle;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= idle;
      k_q <= '0;
      dc_q <= '0;
      i_q <= '0;
      nq_q <= '0;
      addr_q <= '0;
      cen_q <= 1'b1;
      inst_q <= 2'b00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      dc_q <= dc_d;
      i_q <= i_d;
      nq_q <= nq_d;
      addr_q <= addr_d;
      cen_q <= cen_d;
      inst_q <= inst_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: randomized and directed checks of mac_array_ctrl against a cycle-level reference model
module tb_mac_array_ctrl;
  localparam int NC = 256;
  localparam int KB = 0;
  localparam int QB = 16;
  localparam int LL = 10;
  localparam int DL = 11;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [4:0] num_q = '0;
  logic ofifo_full = 1'b0;
  logic mem_cen;
  logic [5:0] mem_addr;
  logic [1:0] inst;
  logic busy, done;
  int checks = 0;
  int errors = 0;
  int done_cyc;
  logic st [0:NC-1];
  logic stall [0:NC-1];
  logic rs [0:NC-1];
  logic [4:0] nqin [0:NC-1];
  logic [4:0] exp_v [0:NC-1];
  logic [5:0] exp_a [0:NC-1];
  logic [4:0] obs_v [0:NC-1];
  logic [5:0] obs_a [0:NC-1];
  mac_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .num_q(num_q), .ofifo_full(ofifo_full),
    .mem_cen(mem_cen), .mem_addr(mem_addr), .inst(inst), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic clear(input int nq);
    for (int c = 0; c < NC; c++) begin
      st[c] = 1'b0;
      stall[c] = 1'b0;
      rs[c] = 1'b0;
      nqin[c] = 5'(nq);
    end
    st[0] = 1'b1;
  endtask
  task automatic model(input int nq);
    int c, q;
    logic [1:0] iss [0:NC-1];
    for (int t = 0; t < NC; t++) begin
      exp_v[t] = 5'b10000;
      exp_a[t] = '0;
      iss[t] = 2'b00;
    end
    c = 1;
    for (int k = 0; k < LL; k++) begin
      exp_v[c][4] = 1'b0;
      exp_a[c] = 6'(KB + k);
      iss[c] = 2'b01;
      c++;
    end
    q = 0;
    while (q < nq && c < NC - DL - 8) begin
      if (!stall[c]) begin
        exp_v[c][4] = 1'b0;
        exp_a[c] = 6'(QB + q);
        iss[c] = 2'b10;
        q++;
      end
      c++;
    end
    done_cyc = c + DL;
    for (int t = 1; t < done_cyc; t++) exp_v[t][1] = 1'b1;
    exp_v[done_cyc][0] = 1'b1;
    for (int t = 1; t < NC; t++) exp_v[t][3:2] = iss[t-1];
  endtask
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      start = st[c];
      ofifo_full = stall[c];
      num_q = nqin[c];
      reset = rs[c];
      @(negedge clk);
      obs_v[c] = {mem_cen, inst, busy, done};
      obs_a[c] = mem_addr;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    ofifo_full = 1'b0;
    reset = 1'b0;
  endtask
  task automatic test_reset;
    clear(0);
    st[0] = 1'b0;
    rs[0] = 1'b1;
    rs[1] = 1'b1;
    run(5);
    for (int c = 1; c < 5; c++) begin
      checks++;
      if (obs_v[c] !== 5'b10000 || obs_a[c] !== 6'd0) begin
        errors++;
        $display("FAIL reset cyc %0d {cen,inst,busy,done} got %b addr %0d want 10000 addr 0", c, obs_v[c], obs_a[c]);
      end
    end
  endtask
  task automatic test_basic;
    clear(4);
    model(4);
    run(done_cyc + 3);
    for (int c = 0; c < done_cyc + 3; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || (!exp_v[c][4] && obs_a[c] !== exp_a[c])) begin
        errors++;
        $display("FAIL basic cyc %0d got %b/%0d want %b/%0d", c, obs_v[c], obs_a[c], exp_v[c], exp_a[c]);
      end
    end
    checks++;
    if (obs_v[26][0] !== 1'b1 || obs_v[25][1] !== 1'b1 || obs_a[14] !== 6'd19) begin
      errors++;
      $display("FAIL basic_timing done26 %b busy25 %b addr14 %0d want 1 1 19", obs_v[26][0], obs_v[25][1], obs_a[14]);
    end
  endtask
  task automatic test_backpressure;
    clear(4);
    stall[12] = 1'b1;
    stall[13] = 1'b1;
    model(4);
    run(done_cyc + 3);
    for (int c = 0; c < done_cyc + 3; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || (!exp_v[c][4] && obs_a[c] !== exp_a[c])) begin
        errors++;
        $display("FAIL backpressure cyc %0d got %b/%0d want %b/%0d", c, obs_v[c], obs_a[c], exp_v[c], exp_a[c]);
      end
    end
    checks++;
    if (obs_v[28][0] !== 1'b1 || obs_v[13][4] !== 1'b1 || obs_a[14] !== 6'd17 || obs_v[14][3:2] !== 2'b00) begin
      errors++;
      $display("FAIL backpressure_timing done28 %b cen13 %b addr14 %0d inst14 %b want 1 1 17 00", obs_v[28][0], obs_v[13][4], obs_a[14], obs_v[14][3:2]);
    end
  endtask
  task automatic test_zero;
    clear(0);
    model(0);
    run(done_cyc + 3);
    for (int c = 0; c < done_cyc + 3; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || (!exp_v[c][4] && obs_a[c] !== exp_a[c]) || obs_v[c][3:2] === 2'b10) begin
        errors++;
        $display("FAIL zero cyc %0d got %b/%0d want %b/%0d", c, obs_v[c], obs_a[c], exp_v[c], exp_a[c]);
      end
    end
    checks++;
    if (obs_v[22][0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_done done22 got %b want 1", obs_v[22][0]);
    end
  endtask
  task automatic test_full;
    clear(31);
    model(31);
    run(done_cyc + 3);
    for (int c = 0; c < done_cyc + 3; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || (!exp_v[c][4] && obs_a[c] !== exp_a[c])) begin
        errors++;
        $display("FAIL full cyc %0d got %b/%0d want %b/%0d", c, obs_v[c], obs_a[c], exp_v[c], exp_a[c]);
      end
    end
    checks++;
    if (obs_a[41] !== 6'd46 || obs_v[41][4] !== 1'b0 || obs_v[53][0] !== 1'b1) begin
      errors++;
      $display("FAIL full_timing addr41 %0d cen41 %b done53 %b want 46 0 1", obs_a[41], obs_v[41][4], obs_v[53][0]);
    end
  endtask
  task automatic test_ignored;
    clear(4);
    model(4);
    st[13] = 1'b1;
    st[done_cyc] = 1'b1;
    for (int c = 5; c < NC; c++) nqin[c] = 5'd9;
    run(done_cyc + 4);
    for (int c = 0; c < done_cyc + 4; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || (!exp_v[c][4] && obs_a[c] !== exp_a[c])) begin
        errors++;
        $display("FAIL ignored cyc %0d got %b/%0d want %b/%0d", c, obs_v[c], obs_a[c], exp_v[c], exp_a[c]);
      end
    end
  endtask
  task automatic test_reset_mid;
    clear(4);
    rs[12] = 1'b1;
    model(4);
    for (int c = 13; c < NC; c++) begin
      exp_v[c] = 5'b10000;
      exp_a[c] = '0;
    end
    run(32);
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || (!exp_v[c][4] && obs_a[c] !== exp_a[c])) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got %b/%0d want %b/%0d", c, obs_v[c], obs_a[c], exp_v[c], exp_a[c]);
      end
    end
    clear(4);
    model(4);
    run(done_cyc + 3);
    for (int c = 0; c < done_cyc + 3; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || (!exp_v[c][4] && obs_a[c] !== exp_a[c])) begin
        errors++;
        $display("FAIL reset_rerun cyc %0d got %b/%0d want %b/%0d", c, obs_v[c], obs_a[c], exp_v[c], exp_a[c]);
      end
    end
  endtask
  task automatic test_random;
    int nq;
    for (int it = 0; it < 8; it++) begin
      nq = int'($urandom_range(0, 31));
      clear(nq);
      for (int c = 1; c < NC; c++) begin
        stall[c] = ($urandom_range(0, 3) == 0);
        nqin[c] = 5'($urandom);
      end
      model(nq);
      for (int c = 1; c <= done_cyc; c++) st[c] = ($urandom_range(0, 7) == 0);
      run(done_cyc + 3);
      for (int c = 0; c < done_cyc + 3; c++) begin
        checks++;
        if (obs_v[c] !== exp_v[c] || (!exp_v[c][4] && obs_a[c] !== exp_a[c])) begin
          errors++;
          $display("FAIL random it %0d nq %0d cyc %0d got %b/%0d want %b/%0d", it, nq, c, obs_v[c], obs_a[c], exp_v[c], exp_a[c]);
        end
      end
    end
  endtask
  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_basic;
    test_backpressure;
    test_zero;
    test_full;
    test_ignored;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
